act_deserializer: RTL and testbench
===================================

Name: act_deserializer

Overview:
- Input-side producer for the fully-parallel FC neuron layer.
- Accepts a stream of WIDTH-bit activations, one per handshake, and assembles them into an IN-entry parallel vector.
- Presents the completed vector to the layer's x[0:IN-1] input under a valid/ready handshake.
- Double-buffered: one bank fills while the other is held stable for the combinational layer.

Parameters:
- WIDTH, 8, activation bit width; matches the layer WIDTH.
- IN, 128, elements per vector; matches the layer IN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  WIDTH  streamed activation.
- s_valid  input  1  s_data valid.
- s_last  input  1  final element of the current frame.
- s_ready  output  1  deserializer can accept an element.
- x  output  WIDTH x [0:IN-1]  assembled vector to the layer.
- x_valid  output  1  x holds a complete frame.
- x_ready  input  1  consumer has latched or used x.
- err_len  output  1  present only with ACT_DESER_ERR_EN; see Optional Feature.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n).
- Storage: two banks, 0 and 1, each IN x WIDTH.
- Pointers and state: wr_sel (bank being filled), rd_sel (bank presented), idx (0..IN-1, element index in wr_sel bank), full[1:0].
- Reset (asynchronous, on rst_n low): all bank entries 0, full=0, wr_sel=0, rd_sel=0, idx=0.
  - Resulting outputs: s_ready=1, x_valid=0, x=all zero.
- Reset mid-frame discards the partial frame and any presented frame; no output glitches beyond the async clear.
- s_ready = !full[wr_sel], combinational from state only; never depends on s_valid.
- Accept: s_valid && s_ready at a rising edge.
  - Writes bank[wr_sel][idx] <= s_data.
  - If idx==IN-1 or s_last: full[wr_sel]<=1, wr_sel toggles, idx<=0 (frame close).
  - Otherwise: idx<=idx+1.
- Short frame: s_last with idx<IN-1 closes the frame. Unwritten entries stay 0, guaranteed by the clear-on-release rule below, so the layer sees zero padding.
- Overlong frame: no s_last by idx==IN-1 still closes the frame at IN elements. The next element starts a new frame at idx 0.
- Present: x = bank[rd_sel]; x_valid = full[rd_sel].
  - x is held bit-stable while x_valid && !x_ready.
- Release: x_valid && x_ready at an edge.
  - full[rd_sel]<=0; all entries of bank[rd_sel] <= 0; rd_sel toggles.
- Latency: frame-closing element accepted at edge N gives x_valid=1 after edge N (visible in cycle N+1), provided that bank is rd_sel.
- Throughput: 1 element/cycle sustained, no bubble at frame boundaries while the consumer releases within IN cycles.
- Both banks full: s_ready=0; the stream stalls until a release.
- Simultaneous release and frame close in the same edge are legal.
  - They always target different banks.
  - The closing bank becomes rd_sel after the toggle; x_valid stays 1 with no gap.
- Simultaneous release and accept into the freed bank cannot happen in the same edge: s_ready is computed from pre-edge state.
- No arithmetic; data passes unmodified and unsigned-agnostic (signedness is interpreted by the layer).

Optional Feature:
- Macro: ACT_DESER_ERR_EN.
- Defined:
  - Port err_len exists; it resets to 0 and is sticky until rst_n.
  - It is set on the edge where a frame closes at idx==IN-1 without s_last (missing last).
  - Early s_last is legal (zero padding) and does not set err_len.
  - Data behaviour is identical with or without the macro.
- Undefined: port err_len and its logic are absent; frame closing behaves exactly as described above.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> immediately s_ready=1, x_valid=0, x all 0; holds after release of reset with s_valid=0.
- Full frame: stream values 1..128, s_last on the 128th, x_ready=0 -> x_valid=1 the cycle after the last accept, x[k]=k+1, stable for 20 held cycles; s_ready stays 1 (second bank free).
- Short frame with padding: after a prior full frame 1..128 is released, stream 5 elements 0xA5 with s_last on the 5th -> x[0..4]=0xA5, x[5..127]=0 (no stale data).
- Back-pressure: x_ready=0, send two complete frames -> after the 256th accept s_ready=0. Then pulse x_ready for 1 cycle -> frame 1 released, frame 2 presented next cycle, s_ready=1.
- Back-to-back streaming: continuous s_valid with x_ready=1 for 4 frames -> 512 accepts in 512 cycles, x_valid pulses once per frame, data correct per frame.
- Async reset mid-frame (at idx=60, one bank full) -> all state cleared; the next frame starts at idx 0 in bank 0. With ACT_DESER_ERR_EN: a 128-element frame without s_last -> err_len=1 after the closing edge, and stays 1 until reset.

Source files
------------

// File: rtl/act_deserializer.sv
// -----------------------------------------------------------------------------
// act_deserializer
//
// Input-side producer for the fully-parallel FC neuron layer. It collects a
// stream of WIDTH-bit activations, one per s_valid/s_ready handshake, into an
// IN-entry vector and presents that vector on x under an x_valid/x_ready
// handshake.
//
// Two banks are used. One fills from the stream while the other is held
// bit-stable for the combinational layer. A frame closes on s_last or on the
// IN-th element, whichever comes first. Entries of a short frame that were
// never written read as zero, because a bank is cleared when it is released.
//
// Parameters:
//   WIDTH    activation bit width (matches the layer WIDTH)
//   IN       elements per vector   (matches the layer IN)
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   s_data   streamed activation
//   s_valid  s_data valid
//   s_last   final element of the current frame
//   s_ready  an element can be accepted (depends on state only)
//   x        assembled vector, x[0] .. x[IN-1]
//   x_valid  x holds a complete frame
//   x_ready  consumer has latched or used x; releases the presented bank
//   err_len  (only with ACT_DESER_ERR_EN) sticky flag: a frame reached IN
//            elements without s_last
//
// Configuration macro:
//   ACT_DESER_ERR_EN  when defined, adds the err_len port and its logic.
//                     Data behaviour is the same either way.
// -----------------------------------------------------------------------------
module act_deserializer #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [0:IN-1][WIDTH-1:0]    x,
  output logic                        x_valid,
  input  logic                        x_ready
`ifdef ACT_DESER_ERR_EN
  ,
  output logic                        err_len
`endif
);

  localparam int               IDX_W    = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  typedef logic [0:IN-1][WIDTH-1:0] bank_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bank_t            r_bank [2];
  logic [1:0]       r_full;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [IDX_W-1:0] r_idx;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic       w_s_ready;
  logic       w_accept;
  logic       w_at_end;
  logic       w_close;
  logic       w_release;
  logic [1:0] w_full_nxt;

  // s_ready looks only at registered state, so a bank freed on this edge is
  // not written on the same edge; the stream picks it up one cycle later.
  assign w_s_ready = ~r_full[r_wr_sel];
  assign w_accept  = s_valid & w_s_ready;
  assign w_at_end  = (r_idx == LAST_IDX);
  assign w_close   = w_accept & (w_at_end | s_last);
  assign w_release = r_full[r_rd_sel] & x_ready;

  // A release and a frame close on the same edge always target different
  // banks: the released bank is full, the closing bank was not.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
    if (w_close)   w_full_nxt[r_wr_sel] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Bank storage
  // ---------------------------------------------------------------------------
  // NOTE: the banks are deliberately reset and cleared as a whole, unlike an
  // ordinary RAM. Zero contents are what the layer sees as padding for short
  // frames, and x must read all-zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_release && (r_rd_sel == 1'(b))) begin
          r_bank[b] <= '0;
        end else if (w_accept && (r_wr_sel == 1'(b))) begin
          r_bank[b][r_idx] <= s_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and full flags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side above sees the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_full <= w_full_nxt;

      if (w_accept) begin
        if (w_close) begin
          r_wr_sel <= ~r_wr_sel;
          r_idx    <= '0;
        end else begin
          r_idx    <= r_idx + 1'b1;
        end
      end

      if (w_release) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

`ifdef ACT_DESER_ERR_EN
  // ---------------------------------------------------------------------------
  // Missing-last detection: a frame forced closed at the IN-th element
  // without s_last. An early s_last is legal padding and never flags.
  // ---------------------------------------------------------------------------
  logic r_err_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_len <= 1'b0;
    end else if (w_accept && w_at_end && !s_last) begin
      r_err_len <= 1'b1;
    end
  end

  assign err_len = r_err_len;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_ready = w_s_ready;
  assign x       = r_bank[r_rd_sel];
  assign x_valid = r_full[r_rd_sel];

endmodule

// File: tb/tb_act_deserializer.sv
// -----------------------------------------------------------------------------
// tb_act_deserializer
//
// Directed bench for act_deserializer. Stimulus pushes the expected vector of
// each frame into a scoreboard queue; a monitor pops and compares whenever a
// new frame is presented on x. Handshake, latency, stall and reset behaviour
// are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_act_deserializer;

  localparam int WIDTH = 8;
  localparam int IN    = 128;

  typedef logic [0:IN-1][WIDTH-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  vec_t             x;
  logic             x_valid;
  logic             x_ready;
`ifdef ACT_DESER_ERR_EN
  logic             err_len;
`endif

  act_deserializer #(
    .WIDTH (WIDTH),
    .IN    (IN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready)
`ifdef ACT_DESER_ERR_EN
    ,
    .err_len (err_len)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and scoreboard
  // ---------------------------------------------------------------------------
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  vec_t sb [$];
  vec_t mon_exp;
  int   pops     = 0;
  bit   shown    = 1'b0;
  int   cyc      = 0;
  int   acc      = 0;
  int   xv_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    int bad = -1;
    chk_cnt++;
    for (int k = 0; k < IN; k++) begin
      if (bad < 0 && act[k] !== exp[k]) bad = k;
    end
    if (bad < 0) pass_cnt++;
    else $display("FAIL %s: element %0d got 0x%0h, expected 0x%0h",
                  name, bad, act[bad], exp[bad]);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_valid && s_ready) acc++;
      if (x_valid === 1'b1)   xv_cyc++;
    end
  end

  // Monitor: one comparison per presented frame.
  always @(negedge rst_n) shown = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      shown = 1'b0;
    end else if (x_valid === 1'b1) begin
      if (!shown) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_frame: x_valid=1 with no frame expected");
        end else begin
          mon_exp = sb.pop_front();
          check_vec("frame_data", x, mon_exp);
          pops++;
        end
        shown = 1'b1;
      end
      if (x_ready) shown = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] pat(input int f, input int k);
    case (f)
      0:       return 8'(k + 1);
      1:       return 8'hA5;
      2:       return 8'h3C;
      3:       return 8'(k) ^ 8'h5A;
      4:       return 8'(255 - k);
      default: return 8'(k * 7 + f * 13);
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready) begin
      n++;
      if (n > 400) begin
        chk_cnt++;
        $display("FAIL accept_timeout: s_ready stuck at 0 for data 0x%0h", d);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input bit with_last);
    vec_t e = '0;
    for (int k = 0; k < n; k++) e[k] = pat(f, k);
    sb.push_back(e);
    for (int k = 0; k < n; k++) send(pat(f, k), with_last && (k == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t exp0;
    bit   stable;
    bit   rdy_ok;
    int   p0, c0, a0, x0;

    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    x_ready = 1'b0;

    // Reset asserted mid-cycle: outputs clear immediately.
    #3 rst_n = 1'b0;
    #1;
    check("reset_s_ready", s_ready, 1);
    check("reset_x_valid", x_valid, 0);
    check_vec("reset_x", x, '0);
`ifdef ACT_DESER_ERR_EN
    check("reset_err_len", err_len, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_s_ready", s_ready, 1);
    check("idle_x_valid", x_valid, 0);
    check_vec("idle_x", x, '0);

    // Full frame 1..128 with s_last on the last element, consumer stalled.
    for (int k = 0; k < IN; k++) exp0[k] = pat(0, k);
    sb.push_back(exp0);
    for (int k = 0; k < IN; k++) begin
      if (k == IN - 1) check("x_valid_before_close", x_valid, 0);
      send(pat(0, k), k == IN - 1);
    end
    check("x_valid_latency", x_valid, 1);
    check("s_ready_second_bank", s_ready, 1);
    stable = 1'b1;
    rdy_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (x !== exp0 || x_valid !== 1'b1) stable = 1'b0;
      if (s_ready !== 1'b1) rdy_ok = 1'b0;
    end
    check("x_held_stable", stable, 1);
    check("s_ready_held", rdy_ok, 1);

    // Release, then two short frames; the second lands in the bank that held
    // 1..128, so its tail must read zero.
    @(posedge clk);
    #1 x_ready = 1'b1;
    @(posedge clk);
    #1 x_ready = 1'b0;
    check("x_valid_after_release", x_valid, 0);
    check_vec("x_after_release", x, '0);
    x_ready = 1'b1;
    send_frame(1, 5, 1'b1);
    send_frame(2, 3, 1'b1);
    repeat (3) @(posedge clk);
    #1 x_ready = 1'b0;
`ifdef ACT_DESER_ERR_EN
    check("err_len_early_last", err_len, 0);
`endif

    // Back-pressure: two complete frames fill both banks; the second has no
    // s_last and closes at IN elements.
    send_frame(3, IN, 1'b1);
    send_frame(4, IN, 1'b0);
    check("s_ready_both_full", s_ready, 0);
    check("x_valid_both_full", x_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check("s_ready_stall_held", s_ready, 0);
    x_ready = 1'b1;
    @(posedge clk);
    #1 x_ready = 1'b0;
    check("x_valid_next_frame", x_valid, 1);
    check("s_ready_after_pulse", s_ready, 1);
`ifdef ACT_DESER_ERR_EN
    check("err_len_missing_last", err_len, 1);
`endif
    @(negedge clk);
    @(posedge clk);
    #1 x_ready = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: four frames, consumer always ready.
    p0 = pops;
    c0 = cyc;
    a0 = acc;
    x0 = xv_cyc;
    for (int f = 5; f < 9; f++) send_frame(f, IN, 1'b1);
    check("b2b_cycles", 32'(cyc - c0), 512);
    check("b2b_accepts", 32'(acc - a0), 512);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_frames", 32'(pops - p0), 4);
    check("b2b_valid_cycles", 32'(xv_cyc - x0), 4);
`ifdef ACT_DESER_ERR_EN
    check("err_len_sticky", err_len, 1);
`endif

    // Async reset mid-frame with one bank full.
    x_ready = 1'b0;
    send_frame(9, IN, 1'b1);
    for (int k = 0; k < 60; k++) send(pat(10, k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_s_ready", s_ready, 1);
    check("midreset_x_valid", x_valid, 0);
    check_vec("midreset_x", x, '0);
`ifdef ACT_DESER_ERR_EN
    check("midreset_err_len", err_len, 0);
`endif
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(11, 2, 1'b1);
    check("post_reset_x_valid", x_valid, 1);
    check("post_reset_s_ready", s_ready, 1);

    // Missing s_last on a fresh frame after reset.
    x_ready = 1'b1;
    send_frame(12, IN, 1'b0);
`ifdef ACT_DESER_ERR_EN
    check("err_len_after_close", err_len, 1);
`endif
    repeat (4) @(posedge clk);
    #1;
`ifdef ACT_DESER_ERR_EN
    check("err_len_holds", err_len, 1);
`endif
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
